// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle controller: FSM states and opcode class encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_LD,
        MEM_LD,
        WB_LD,
        EXEC_ST,
        MEM_ST,
        EXEC_BR,
        TRAP
    } state_e;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_LD,
        CLS_ST,
        CLS_BR
    } opclass_e;

    localparam logic [2:0] OPC_R  = 3'b000;
    localparam logic [2:0] OPC_LD = 3'b011;
    localparam logic [2:0] OPC_ST = 3'b010;
    localparam logic [2:0] OPC_BR = 3'b100;

endpackage

// File: rtl/multicycle_ctrl_opclass_decode.sv
// Combinational opcode-class decoder, kept separate so a pipelined controller can reuse it.
module opclass_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] i_class,
    output opclass_e   o_class,
    output logic       o_illegal
);

    always_comb begin
        o_class   = CLS_R;
        o_illegal = 1'b0;
        case (i_class)
            OPC_R:   o_class = CLS_R;
            OPC_LD:  o_class = CLS_LD;
            OPC_ST:  o_class = CLS_ST;
            OPC_BR:  o_class = CLS_BR;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch over a req/ack memory port, then execute/memory/writeback.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OP_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic [2:0]       alu_control,
    output logic             alu_src,
    output logic             result_src,
    output logic             sx_ch,
    output logic             trap,
    output logic [CNT_W-1:0] instr_retired
);

    state_e          r_state;
    state_e          w_next;
    logic [OP_W-1:0] r_op_q;
    opclass_e        w_class;
    logic            w_illegal;
    logic            w_retire;
    logic            w_unused_op;

    opclass_decode u_opclass_decode (
        .i_class   (op[OP_W-1:OP_W-3]),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    assign w_unused_op = &{1'b0, r_op_q[OP_W-1:3], op[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op_q <= op;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (mem_ack) w_next = DECODE;
            DECODE: begin
                if (w_illegal) begin
                    w_next = TRAP;
                end else begin
                    case (w_class)
                        CLS_R:   w_next = EXEC_R;
                        CLS_LD:  w_next = EXEC_LD;
                        CLS_ST:  w_next = EXEC_ST;
                        default: w_next = EXEC_BR;
                    endcase
                end
            end
            EXEC_R:  w_next = WB_R;
            WB_R:    w_next = FETCH;
            EXEC_LD: w_next = MEM_LD;
            MEM_LD:  if (mem_ack) w_next = WB_LD;
            WB_LD:   w_next = FETCH;
            EXEC_ST: w_next = MEM_ST;
            MEM_ST:  if (mem_ack) w_next = FETCH;
            EXEC_BR: w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
    end

    // Outputs are forced low while rst_n is asserted so an abandoned access drops at once.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_src    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        reg_we      = 1'b0;
        alu_control = 3'b000;
        alu_src     = 1'b0;
        result_src  = 1'b0;
        sx_ch       = 1'b0;
        trap        = 1'b0;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                EXEC_R: begin
                    alu_control = r_op_q[2:0];
                end
                WB_R: begin
                    reg_we = 1'b1;
                end
                EXEC_LD: begin
                    alu_control = r_op_q[2:0];
                    alu_src     = 1'b1;
                end
                MEM_LD: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                end
                WB_LD: begin
                    reg_we     = 1'b1;
                    result_src = 1'b1;
                end
                EXEC_ST: begin
                    alu_control = r_op_q[2:0];
                    alu_src     = 1'b1;
                    sx_ch       = 1'b1;
                end
                MEM_ST: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    mem_we   = 1'b1;
                    sx_ch    = 1'b1;
                end
                EXEC_BR: begin
                    alu_control = r_op_q[2:0];
                    sx_ch       = 1'b1;
                    pc_src      = zero;
                    pc_we       = zero;
                end
                TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_retire = (r_state == WB_R) || (r_state == WB_LD) || (r_state == EXEC_BR) ||
                      ((r_state == MEM_ST) && mem_ack);

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign instr_retired = r_retired;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign instr_retired   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             addr_src;
        logic             ir_we;
        logic             pc_we;
        logic             pc_src;
        logic             reg_we;
        logic [2:0]       alu;
        logic             alu_src;
        logic             result_src;
        logic             sx_ch;
        logic             trap;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [6:0]       op;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             addr_src;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             reg_we;
    logic [2:0]       alu_control;
    logic             alu_src;
    logic             result_src;
    logic             sx_ch;
    logic             trap;
    logic [CNT_W-1:0] instr_retired;

    exp_t             expQueue[$];
    string            nameQueue[$];
    int               checkCount = 0;
    int               errorCount = 0;
    logic [CNT_W-1:0] retModel   = '0;

    multicycle_ctrl #(.CNT_W(CNT_W), .OP_W(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .zero          (zero),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_src      (addr_src),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .reg_we        (reg_we),
        .alu_control   (alu_control),
        .alu_src       (alu_src),
        .result_src    (result_src),
        .sx_ch         (sx_ch),
        .trap          (trap),
        .instr_retired (instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written expected output patterns for each controller phase
    function automatic exp_t eNone();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t eFetch(input logic ack);
        exp_t e;
        e = '0; e.mem_req = 1'b1; e.ir_we = ack; e.pc_we = ack;
        return e;
    endfunction

    function automatic exp_t eExecR(input logic [2:0] a);
        exp_t e;
        e = '0; e.alu = a;
        return e;
    endfunction

    function automatic exp_t eWbR();
        exp_t e;
        e = '0; e.reg_we = 1'b1;
        return e;
    endfunction

    function automatic exp_t eExecLd(input logic [2:0] a);
        exp_t e;
        e = '0; e.alu = a; e.alu_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t eMemLd();
        exp_t e;
        e = '0; e.mem_req = 1'b1; e.addr_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t eWbLd();
        exp_t e;
        e = '0; e.reg_we = 1'b1; e.result_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t eExecSt(input logic [2:0] a);
        exp_t e;
        e = '0; e.alu = a; e.alu_src = 1'b1; e.sx_ch = 1'b1;
        return e;
    endfunction

    function automatic exp_t eMemSt();
        exp_t e;
        e = '0; e.mem_req = 1'b1; e.addr_src = 1'b1; e.mem_we = 1'b1; e.sx_ch = 1'b1;
        return e;
    endfunction

    function automatic exp_t eExecBr(input logic [2:0] a, input logic z);
        exp_t e;
        e = '0; e.alu = a; e.sx_ch = 1'b1; e.pc_src = z; e.pc_we = z;
        return e;
    endfunction

    function automatic exp_t eTrap();
        exp_t e;
        e = '0; e.trap = 1'b1;
        return e;
    endfunction

    // Drives one cycle of inputs and queues what the DUT should show during that cycle
    task automatic applyStimulus(input logic rstv, input logic ack, input logic z,
                                 input logic retire, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n   = rstv;
        mem_ack = ack;
        zero    = z;
        if (!rstv) retModel = '0;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        e.ret = retModel;
`else
        e.ret = '0;
`endif
        expQueue.push_back(e);
        nameQueue.push_back(nm);
        if (retire && rstv) retModel = retModel + 1'b1;
    endtask

    task automatic checkOutput();
        exp_t  e;
        exp_t  a;
        string nm;
        e  = expQueue.pop_front();
        nm = nameQueue.pop_front();
        a  = '{mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we, alu_control,
               alu_src, result_src, sx_ch, trap, instr_retired};
        checkCount++;
        if (a !== e) begin
            errorCount++;
            $display("[TB] FAIL %s: got req=%b we=%b as=%b ir=%b pcwe=%b pcs=%b rwe=%b alu=%h asrc=%b rs=%b sx=%b trap=%b ret=%0d, expected req=%b we=%b as=%b ir=%b pcwe=%b pcs=%b rwe=%b alu=%h asrc=%b rs=%b sx=%b trap=%b ret=%0d",
                     nm, a.mem_req, a.mem_we, a.addr_src, a.ir_we, a.pc_we, a.pc_src, a.reg_we,
                     a.alu, a.alu_src, a.result_src, a.sx_ch, a.trap, a.ret,
                     e.mem_req, e.mem_we, e.addr_src, e.ir_we, e.pc_we, e.pc_src, e.reg_we,
                     e.alu, e.alu_src, e.result_src, e.sx_ch, e.trap, e.ret);
        end
    endtask

    // Monitor compares mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (expQueue.size() > 0) checkOutput();
    end

    task automatic runRType(input logic [6:0] opcode, input string tag);
        op = opcode;
        applyStimulus(1, 1, 0, 0, eFetch(1), {tag, "_fetch"});
        applyStimulus(1, 1, 0, 0, eNone(), {tag, "_decode"});
        applyStimulus(1, 1, 0, 0, eExecR(opcode[2:0]), {tag, "_exec"});
        applyStimulus(1, 1, 0, 1, eWbR(), {tag, "_wb"});
    endtask

    initial begin
        rst_n   = 1'b0;
        op      = 7'b0;
        zero    = 1'b0;
        mem_ack = 1'b0;

        applyStimulus(0, 0, 0, 0, eNone(), "reset0");
        applyStimulus(0, 1, 0, 0, eNone(), "reset1");
        applyStimulus(1, 0, 0, 0, eFetch(0), "fetch_wait");

        runRType(7'b0000010, "rtype");

        op = 7'b0110000;
        applyStimulus(1, 1, 0, 0, eFetch(1), "ld_fetch");
        applyStimulus(1, 0, 0, 0, eNone(), "ld_decode");
        applyStimulus(1, 0, 0, 0, eExecLd(3'b000), "ld_exec");
        applyStimulus(1, 0, 0, 0, eMemLd(), "ld_mem_w1");
        applyStimulus(1, 0, 0, 0, eMemLd(), "ld_mem_w2");
        applyStimulus(1, 1, 0, 0, eMemLd(), "ld_mem_ack");
        applyStimulus(1, 0, 0, 1, eWbLd(), "ld_wb");

        op = 7'b0100000;
        applyStimulus(1, 0, 0, 0, eFetch(0), "st_fetch_wait");
        applyStimulus(1, 1, 0, 0, eFetch(1), "st_fetch");
        applyStimulus(1, 0, 0, 0, eNone(), "st_decode");
        applyStimulus(1, 0, 0, 0, eExecSt(3'b000), "st_exec");
        applyStimulus(1, 0, 0, 0, eMemSt(), "st_mem_w");
        applyStimulus(1, 1, 0, 1, eMemSt(), "st_mem_ack");

        op = 7'b1000001;
        applyStimulus(1, 1, 0, 0, eFetch(1), "br1_fetch");
        applyStimulus(1, 1, 1, 0, eNone(), "br1_decode");
        applyStimulus(1, 1, 1, 1, eExecBr(3'b001, 1), "br1_taken");
        applyStimulus(1, 1, 0, 0, eFetch(1), "br0_fetch");
        applyStimulus(1, 1, 0, 0, eNone(), "br0_decode");
        applyStimulus(1, 1, 0, 1, eExecBr(3'b001, 0), "br0_not_taken");
        applyStimulus(1, 0, 0, 0, eFetch(0), "br0_next_fetch");

        op = 7'b0110101;
        applyStimulus(1, 1, 0, 0, eFetch(1), "ldr_fetch");
        applyStimulus(1, 0, 0, 0, eNone(), "ldr_decode");
        applyStimulus(1, 0, 0, 0, eExecLd(3'b101), "ldr_exec");
        applyStimulus(1, 0, 0, 0, eMemLd(), "ldr_mem_wait");
        applyStimulus(0, 0, 0, 0, eNone(), "ldr_reset_mid_access");
        applyStimulus(1, 0, 0, 0, eFetch(0), "ldr_restart_fetch");

        op = 7'b1110000;
        applyStimulus(1, 1, 0, 0, eFetch(1), "trap_fetch");
        applyStimulus(1, 1, 0, 0, eNone(), "trap_decode");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, i[0], 0, eTrap(), "trap_hold");
        end
        applyStimulus(0, 1, 0, 0, eNone(), "trap_reset");
        applyStimulus(1, 0, 0, 0, eFetch(0), "trap_restart_fetch");

        for (int i = 0; i < 16; i++) begin
            runRType({4'b0000, i[2:0]}, "retire_r");
        end
        applyStimulus(1, 0, 0, 0, eFetch(0), "retire_final_fetch");

        repeat (3) @(posedge clk);
        checkCount++;
        if (expQueue.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQueue.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
